// File: rtl/mux_bist_ctrl.sv
// BIST sequencer for a 2:1 mux: walks all 8 {sel,I0,I1} vectors, checks y against
// the golden mux function and reports pass, error count, first failing vector and stuck-at class.
module mux_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_y,
  output logic             dut_sel,
  output logic             dut_i0,
  output logic             dut_i1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       first_fail,
  output logic [1:0]       fault_class
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       vec;
  logic [CNT_W-1:0] settle_cnt;
  logic [2:0]       miss_exp1;
  logic [2:0]       miss_exp0;
  logic             exp_y;
  logic             miss;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // A stuck-at class needs every vector of one polarity to miss and none of the other.
  function automatic logic [1:0] classify(input logic [2:0] m1, input logic [2:0] m0);
    if (m1 == 3'd0 && m0 == 3'd0) return 2'b00;
    if (m1 == 3'd4 && m0 == 3'd0) return 2'b01;
    if (m0 == 3'd4 && m1 == 3'd0) return 2'b10;
    return 2'b11;
  endfunction

  assign exp_y   = vec[2] ? vec[0] : vec[1];
  assign miss    = (dut_y != exp_y);
  assign dut_sel = vec[2];
  assign dut_i0  = vec[1];
  assign dut_i1  = vec[0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = CHECK;
      CHECK:   state_nxt = (vec == 3'd7) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vec         <= 3'd0;
      settle_cnt  <= '0;
      miss_exp1   <= 3'd0;
      miss_exp0   <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_cnt     <= '0;
      first_fail  <= 3'd0;
      fault_class <= 2'b00;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec         <= 3'd0;
            settle_cnt  <= '0;
            busy        <= 1'b1;
            err_cnt     <= '0;
            first_fail  <= 3'd0;
            pass        <= 1'b0;
            fault_class <= 2'b00;
            miss_exp1   <= 3'd0;
            miss_exp0   <= 3'd0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + CNT_W'(1);
        CHECK: begin
          if (miss) begin
            err_cnt <= sat_inc(err_cnt);
            if (miss_exp1 == 3'd0 && miss_exp0 == 3'd0) first_fail <= vec;
            if (exp_y) miss_exp1 <= miss_exp1 + 3'd1;
            else       miss_exp0 <= miss_exp0 + 3'd1;
          end
          if (vec != 3'd7) begin
            vec        <= vec + 3'd1;
            settle_cnt <= '0;
          end
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          pass        <= (miss_exp1 == 3'd0 && miss_exp0 == 3'd0);
          fault_class <= classify(miss_exp1, miss_exp0);
          vec         <= 3'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_bist_ctrl.sv
// Scoreboard bench for mux_bist_ctrl: behavioural faulty-mux models feed dut_y, expected
// run results are queued at start and checked by a monitor whenever done pulses.
module tb_mux_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic y_a, y_b;
  logic sel_a, i0_a, i1_a, busy_a, done_a, pass_a;
  logic sel_b, i0_b, i1_b, busy_b, done_b, pass_b;
  logic [3:0] err_a;
  logic [1:0] err_b;
  logic [2:0] ff_a, ff_b;
  logic [1:0] fc_a, fc_b;
  int mode = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic       pass;
    int         err;
    logic [2:0] ff;
    logic [1:0] fc;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // 0 golden, 1 y stuck-at-0, 2 y stuck-at-1, 3 inverted, 4 sel stuck-at-0
  function automatic logic mux_model(input int m, input logic s, input logic a, input logic b);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~(s ? b : a);
      4:       return a;
      default: return s ? b : a;
    endcase
  endfunction

  assign y_a = mux_model(mode, sel_a, i0_a, i1_a);
  assign y_b = mux_model(mode, sel_b, i0_b, i1_b);

  mux_bist_ctrl #(.SETTLE_CYCLES(2), .ERR_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_y(y_a),
    .dut_sel(sel_a), .dut_i0(i0_a), .dut_i1(i1_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_fail(ff_a), .fault_class(fc_a)
  );

  mux_bist_ctrl #(.SETTLE_CYCLES(2), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_y(y_b),
    .dut_sel(sel_b), .dut_i0(i0_b), .dut_i1(i1_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_fail(ff_b), .fault_class(fc_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_a) begin
        if (qa.size() == 0) chk("unexpected_done_a", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_pass", pass_a, e.pass);
          chk("a_err_cnt", err_a, e.err);
          chk("a_first_fail", ff_a, e.ff);
          chk("a_fault_class", fc_a, e.fc);
          chk("a_busy_at_done", busy_a, 0);
          chk("a_done_cycle", cyc, e.cyc);
        end
      end
      if (done_b) begin
        if (qb.size() == 0) chk("unexpected_done_b", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_pass", pass_b, e.pass);
          chk("b_err_cnt", err_b, e.err);
          chk("b_first_fail", ff_b, e.ff);
          chk("b_fault_class", fc_b, e.fc);
          chk("b_busy_at_done", busy_b, 0);
          chk("b_done_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      chk("done_timeout", qa.size() + qb.size(), 0);
      qa.delete();
      qb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_a(input int m, input logic p, input int err, input logic [2:0] ff,
                       input logic [1:0] fc);
    exp_t e;
    mode = m;
    @(negedge clk);
    e.pass = p; e.err = err; e.ff = ff; e.fc = fc; e.cyc = cyc + 26;
    qa.push_back(e);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_after_start", busy_a, 1);
    wait_drain();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_outs"}, {sel_a, i0_a, i1_a, busy_a, done_a, pass_a, err_a, ff_a, fc_a}, 0);
    chk({tag, "_b_outs"}, {sel_b, i0_b, i1_b, busy_b, done_b, pass_b, err_b, ff_b, fc_b}, 0);
  endtask

  initial begin
    exp_t e;
    int c0;
    int dones;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_a(0, 1'b1, 0, 3'b000, 2'b00);
    run_a(1, 1'b0, 4, 3'b010, 2'b01);
    run_a(2, 1'b0, 4, 3'b000, 2'b10);
    run_a(4, 1'b0, 2, 3'b101, 2'b11);
    run_a(3, 1'b0, 8, 3'b000, 2'b11);

    // Saturating counter on the narrow instance
    mode = 3;
    @(negedge clk);
    e.pass = 1'b0; e.err = 3; e.ff = 3'b000; e.fc = 2'b11; e.cyc = cyc + 26;
    qb.push_back(e);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_drain();

    // start held high through DONE: second run begins on the IDLE edge
    mode = 0;
    @(negedge clk);
    e.pass = 1'b1; e.err = 0; e.ff = 3'b000; e.fc = 2'b00; e.cyc = cyc + 26;
    qa.push_back(e);
    e.cyc = cyc + 52;
    qa.push_back(e);
    start_a = 1'b1;
    repeat (30) @(negedge clk);
    start_a = 1'b0;
    wait_drain();

    // start re-pulsed mid-run is ignored; reset at vec 4 aborts with no done
    mode = 0;
    @(negedge clk);
    c0 = cyc + 1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ({sel_a, i0_a, i1_a} == 3'd4) break;
      @(negedge clk);
    end
    chk("vec4_cycle", cyc, c0 + 12);
    chk("busy_mid_run", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    chk("no_done_after_abort", dones, 0);
    check_zero("post_abort");

    run_a(0, 1'b1, 0, 3'b000, 2'b00);
    chk("scoreboard_empty", qa.size() + qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
